// File: rtl/soc_irq_ctrl_if.sv
// AXI-Lite register port of soc_irq_ctrl: the master issues AW/W/AR and takes B/R, the slave answers.
interface soc_irq_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/soc_irq_ctrl.sv
// Interrupt controller: irq_src latched into PENDING, masked by ENABLE, registered irq_out; AXI-Lite answers 1 cycle after ready, one write outstanding (AW/W held off until B is taken).
// Macro SOC_IRQ_CTRL_EDGE_EN adds EDGE_SEL at 0x14 and a per-source rising-edge detector; without it every source is level-sensitive.
module soc_irq_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_IRQ    = 8
) (
   input  logic               ACLK,
   input  logic               ARESET,
   soc_irq_ctrl_if.slave      bus,
   input  logic [NUM_IRQ-1:0] irq_src,
   output logic               irq_out
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [ADDR_WIDTH-1:0] OFS_RAW     = ADDR_WIDTH'(5'h00);
   localparam logic [ADDR_WIDTH-1:0] OFS_ENABLE  = ADDR_WIDTH'(5'h04);
   localparam logic [ADDR_WIDTH-1:0] OFS_PENDING = ADDR_WIDTH'(5'h08);
   localparam logic [ADDR_WIDTH-1:0] OFS_CLEAR   = ADDR_WIDTH'(5'h0C);
   localparam logic [ADDR_WIDTH-1:0] OFS_CLAIM   = ADDR_WIDTH'(5'h10);

   logic [NUM_IRQ-1:0]    enable, pending, active, set_vec, clr_vec, wm_irq, wd_irq;
   logic                  aw_rdy, b_vld, ar_rdy, r_vld, irq_q;
   logic [1:0]            b_resp, r_resp;
   logic [DATA_WIDTH-1:0] r_dat, rd_val, wmask, wdat_m;
   logic                  wr_fire, ar_fire, wr_enable, wr_clear, wr_ok, rd_err;
   logic                  claim_vld;
   logic [4:0]            claim_idx;

   assign bus.AWREADY = aw_rdy;
   assign bus.WREADY  = aw_rdy;
   assign bus.BVALID  = b_vld;
   assign bus.BRESP   = b_resp;
   assign bus.ARREADY = ar_rdy;
   assign bus.RVALID  = r_vld;
   assign bus.RRESP   = r_resp;
   assign bus.RDATA   = r_dat;
   assign irq_out     = irq_q;

   // Ready is only raised once per offered pair; the handshake edge is the one where ready is high.
   assign wr_fire = aw_rdy && bus.AWVALID && bus.WVALID;
   assign ar_fire = ar_rdy && bus.ARVALID;

   always_comb begin
      wmask = '0;
      for (int b = 0; b < DATA_WIDTH/8; b++) wmask[8*b +: 8] = {8{bus.WSTRB[b]}};
   end

   assign wdat_m    = bus.WDATA & wmask;
   assign wd_irq    = wdat_m[NUM_IRQ-1:0];
   assign wm_irq    = wmask[NUM_IRQ-1:0];
   assign wr_enable = wr_fire && (bus.AWADDR == OFS_ENABLE);
   assign wr_clear  = wr_fire && (bus.AWADDR == OFS_CLEAR);
   assign clr_vec   = wr_clear ? wd_irq : '0;

`ifdef SOC_IRQ_CTRL_EDGE_EN
   localparam logic [ADDR_WIDTH-1:0] OFS_EDGE_SEL = ADDR_WIDTH'(5'h14);
   logic [NUM_IRQ-1:0] edge_sel, src_d;
   logic               wr_edge;

   assign wr_edge = wr_fire && (bus.AWADDR == OFS_EDGE_SEL);
   // Edge-mode sources only set on a 0->1 transition of the sampled input.
   assign set_vec = irq_src & ~(edge_sel & src_d);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         edge_sel <= '0;
         src_d    <= '0;
      end else begin
         src_d <= irq_src;
         if (wr_edge) edge_sel <= (edge_sel & ~wm_irq) | wd_irq;
      end
   end
`else
   logic wr_edge;
   assign wr_edge = 1'b0;
   assign set_vec = irq_src;
`endif

   assign wr_ok  = wr_enable || wr_clear || wr_edge;
   assign active = pending & enable;
   assign claim_vld = |active;

   always_comb begin
      claim_idx = '0;
      for (int i = NUM_IRQ-1; i >= 0; i--) begin
         if (active[i]) claim_idx = 5'(i);
      end
   end

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      case (bus.ARADDR)
         OFS_RAW:     rd_val = DATA_WIDTH'(irq_src);
         OFS_ENABLE:  rd_val = DATA_WIDTH'(enable);
         OFS_PENDING: rd_val = DATA_WIDTH'(pending);
         OFS_CLAIM: begin
            rd_val[DATA_WIDTH-1] = claim_vld;
            rd_val[4:0]          = claim_idx;
         end
`ifdef SOC_IRQ_CTRL_EDGE_EN
         OFS_EDGE_SEL: rd_val = DATA_WIDTH'(edge_sel);
`endif
         default:     rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_rdy  <= 1'b0;
         b_vld   <= 1'b0;
         b_resp  <= RESP_OKAY;
         ar_rdy  <= 1'b0;
         r_vld   <= 1'b0;
         r_resp  <= RESP_OKAY;
         r_dat   <= '0;
         enable  <= '0;
         pending <= '0;
         irq_q   <= 1'b0;
      end else begin
         aw_rdy <= bus.AWVALID && bus.WVALID && !aw_rdy && (!b_vld || bus.BREADY);
         ar_rdy <= bus.ARVALID && !ar_rdy && (!r_vld || bus.RREADY);

         if (wr_fire) begin
            b_vld  <= 1'b1;
            b_resp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (bus.BREADY) begin
            b_vld <= 1'b0;
         end

         if (ar_fire) begin
            r_vld  <= 1'b1;
            r_dat  <= rd_val;
            r_resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (bus.RREADY) begin
            r_vld <= 1'b0;
         end

         if (wr_enable) enable <= (enable & ~wm_irq) | wd_irq;
         // A set in the same cycle as a clear wins, so held level sources re-pend at once.
         pending <= (pending & ~clr_vec) | set_vec;
         irq_q   <= claim_vld;
      end
   end

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Self-checking bench for soc_irq_ctrl (NUM_IRQ=8); bus responses are checked against a queue of expected results.
module tb_soc_irq_ctrl;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] irq_src = 8'h00;
   logic       irq_out;
   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   soc_irq_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   soc_irq_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_IRQ(8)) dut (
      .ACLK(clk), .ARESET(rst), .bus(bus), .irq_src(irq_src), .irq_out(irq_out)
   );

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdelay, output logic [1:0] resp);
      int cyc;
      @(posedge clk); #1;
      bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
      cyc = 0;
      while (bus.AWREADY !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL wr_timeout: AWREADY still low after %0d cycles, addr %h", cyc, a); end
      @(posedge clk); #1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      cyc = 0;
      while (bus.BVALID !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL b_timeout: BVALID still low after %0d cycles, addr %h", cyc, a); end
      resp = bus.BRESP;
      repeat (bdelay) @(posedge clk);
      if (bdelay > 0) #1;
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      int cyc;
      @(posedge clk); #1;
      bus.ARADDR = a; bus.ARVALID = 1'b1;
      cyc = 0;
      while (bus.ARREADY !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL rd_timeout: ARREADY still low after %0d cycles, addr %h", cyc, a); end
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      cyc = 0;
      while (bus.RVALID !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL r_timeout: RVALID still low after %0d cycles, addr %h", cyc, a); end
      d = bus.RDATA; resp = bus.RRESP;
      bus.RREADY = 1'b1;
      @(posedge clk); #1;
      bus.RREADY = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0]  addrs [5] = '{5'h00, 5'h04, 5'h08, 5'h10, 5'h14};
      int          n_addr;
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
`ifdef SOC_IRQ_CTRL_EDGE_EN
      n_addr = 5;
`else
      n_addr = 4;
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, irq_out} !== 6'b0) begin
         n_err++; $display("FAIL reset_flags: got %b want 000000",
                           {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, irq_out});
      end
      n_cmp++;
      if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0) begin
         n_err++; $display("FAIL reset_data: BRESP %b RRESP %b RDATA %h want all 0", bus.BRESP, bus.RRESP, bus.RDATA);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < n_addr; i++) begin
         sb.push_back(exp_t'{OKAY, 32'h0});
         do_read(addrs[i], d, r);
         e = sb.pop_front();
         n_cmp++;
         if (d !== e.data || r !== e.resp) begin
            n_err++; $display("FAIL reset_read[%h]: got %h/%b want %h/%b", addrs[i], d, r, e.data, e.resp);
         end
      end
      n_cmp++;
      if (irq_out !== 1'b0) begin n_err++; $display("FAIL reset_irq_out: got %b want 0", irq_out); end
   endtask

   task automatic test_pulse();
      logic [4:0]  addrs [2] = '{5'h08, 5'h10};
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_write(5'h04, 32'h1, 4'hF, 0, r);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.resp) begin n_err++; $display("FAIL pulse_wr_enable: BRESP %b want %b", r, e.resp); end
      irq_src = 8'h01;
      @(posedge clk); #1;
      irq_src = 8'h00;
      n_cmp++;
      if (irq_out !== 1'b0) begin n_err++; $display("FAIL pulse_irq_early: got %b want 0", irq_out); end
      @(posedge clk); #1;
      n_cmp++;
      if (irq_out !== 1'b1) begin n_err++; $display("FAIL pulse_irq_out: got %b want 1", irq_out); end
      sb.push_back(exp_t'{OKAY, 32'h0000_0001});
      sb.push_back(exp_t'{OKAY, 32'h8000_0000});
      for (int i = 0; i < 2; i++) begin
         do_read(addrs[i], d, r);
         e = sb.pop_front();
         n_cmp++;
         if (d !== e.data || r !== e.resp) begin
            n_err++; $display("FAIL pulse_read[%h]: got %h/%b want %h/%b", addrs[i], d, r, e.data, e.resp);
         end
      end
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_write(5'h0C, 32'h1, 4'hF, 0, r);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.resp) begin n_err++; $display("FAIL pulse_wr_clear: BRESP %b want %b", r, e.resp); end
      n_cmp++;
      if (irq_out !== 1'b0) begin n_err++; $display("FAIL pulse_irq_after_clear: got %b want 0", irq_out); end
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_read(5'h08, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL pulse_pending_cleared: got %h/%b want %h/%b", d, r, e.data, e.resp); end
   endtask

   task automatic test_level();
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      do_write(5'h04, 32'h08, 4'hF, 0, r);
      irq_src = 8'h0C;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(exp_t'{OKAY, 32'h8000_0003});
      do_read(5'h10, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL level_claim: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      n_cmp++;
      if (irq_out !== 1'b1) begin n_err++; $display("FAIL level_irq_out: got %b want 1", irq_out); end
      do_write(5'h0C, 32'h0C, 4'hF, 0, r);
      sb.push_back(exp_t'{OKAY, 32'h0C});
      do_read(5'h08, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL level_set_wins: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      irq_src = 8'h00;
      do_write(5'h0C, 32'h0C, 4'hF, 0, r);
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_read(5'h10, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL level_claim_empty: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      n_cmp++;
      if (irq_out !== 1'b0) begin n_err++; $display("FAIL level_irq_low: got %b want 0", irq_out); end
   endtask

   task automatic test_errors();
      logic [4:0]  waddr [4] = '{5'h00, 5'h06, 5'h08, 5'h14};
      logic [4:0]  raddr [3] = '{5'h0C, 5'h05, 5'h14};
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      int          n_wr;
      int          n_rd;
`ifdef SOC_IRQ_CTRL_EDGE_EN
      n_wr = 3; n_rd = 2;
`else
      n_wr = 4; n_rd = 3;
`endif
      do_write(5'h04, 32'h0A, 4'hF, 0, r);
      for (int i = 0; i < n_wr; i++) begin
         sb.push_back(exp_t'{SLVERR, 32'h0});
         do_write(waddr[i], 32'hFFFF_FFFF, 4'hF, 0, r);
         e = sb.pop_front();
         n_cmp++;
         if (r !== e.resp) begin n_err++; $display("FAIL err_write[%h]: BRESP %b want %b", waddr[i], r, e.resp); end
      end
      for (int i = 0; i < n_rd; i++) begin
         sb.push_back(exp_t'{SLVERR, 32'h0});
         do_read(raddr[i], d, r);
         e = sb.pop_front();
         n_cmp++;
         if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL err_read[%h]: got %h/%b want %h/%b", raddr[i], d, r, e.data, e.resp); end
      end
      sb.push_back(exp_t'{OKAY, 32'h0A});
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_read(5'h04, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL err_enable_kept: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      do_read(5'h08, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL err_pending_kept: got %h/%b want %h/%b", d, r, e.data, e.resp); end
   endtask

   task automatic test_strobe();
      logic [4:0]  wa [5] = '{5'h04, 5'h04, 5'h04, 5'h0C, 5'h0C};
      logic [31:0] wd [5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_A5FF, 32'h0000_0003, 32'hFFFF_FF03};
      logic [3:0]  ws [5] = '{4'hF, 4'h2, 4'h3, 4'h0, 4'h1};
      logic [4:0]  ra [5] = '{5'h04, 5'h04, 5'h04, 5'h08, 5'h08};
      logic [31:0] rd [5] = '{32'hFF, 32'hFF, 32'hFF, 32'h03, 32'h00};
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      irq_src = 8'h03;
      @(posedge clk); #1;
      irq_src = 8'h00;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(exp_t'{OKAY, rd[i]});
         do_write(wa[i], wd[i], ws[i], 0, r);
         n_cmp++;
         if (r !== OKAY) begin n_err++; $display("FAIL strobe_bresp[%0d]: got %b want %b", i, r, OKAY); end
         do_read(ra[i], d, r);
         e = sb.pop_front();
         n_cmp++;
         if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL strobe_read[%0d]: got %h/%b want %h/%b", i, d, r, e.data, e.resp); end
      end
   endtask

`ifdef SOC_IRQ_CTRL_EDGE_EN
   task automatic test_edge();
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      do_write(5'h04, 32'h0, 4'hF, 0, r);
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_write(5'h14, 32'h02, 4'hF, 0, r);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.resp) begin n_err++; $display("FAIL edge_wr_sel: BRESP %b want %b", r, e.resp); end
      sb.push_back(exp_t'{OKAY, 32'h02});
      do_read(5'h14, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL edge_sel_read: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      irq_src = 8'h02;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(exp_t'{OKAY, 32'h02});
      do_read(5'h08, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL edge_pend_once: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      do_write(5'h0C, 32'h02, 4'hF, 0, r);
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_read(5'h08, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL edge_held_no_repend: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      irq_src = 8'h00;
      repeat (2) @(posedge clk);
      #1 irq_src = 8'h02;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(exp_t'{OKAY, 32'h02});
      do_read(5'h08, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL edge_next_rise: got %h/%b want %h/%b", d, r, e.data, e.resp); end
      irq_src = 8'h00;
      do_write(5'h14, 32'h0, 4'hF, 0, r);
      do_write(5'h0C, 32'hFF, 4'hF, 0, r);
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      int          cyc;
      bit          held;
      bus.BREADY = 1'b0;
      sb.push_back(exp_t'{OKAY, 32'h0});
      @(posedge clk); #1;
      bus.AWADDR = 5'h04; bus.WDATA = 32'h05; bus.WSTRB = 4'hF; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
      cyc = 0;
      while (bus.AWREADY !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL b2b_timeout: first AWREADY still low after %0d cycles", cyc); end
      @(posedge clk); #1;
      bus.WDATA = 32'h06;
      e = sb.pop_front();
      n_cmp++;
      if (bus.BVALID !== 1'b1 || bus.BRESP !== e.resp) begin
         n_err++; $display("FAIL b2b_first_b: BVALID %b BRESP %b want 1/%b", bus.BVALID, bus.BRESP, e.resp);
      end
      held = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.BVALID !== 1'b1 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) held = 1'b0;
      end
      n_cmp++;
      if (!held) begin n_err++; $display("FAIL b2b_stall: BVALID/AWREADY/WREADY = %b%b%b want 100", bus.BVALID, bus.AWREADY, bus.WREADY); end
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
      n_cmp++;
      if (bus.BVALID !== 1'b0) begin n_err++; $display("FAIL b2b_b_done: BVALID %b want 0", bus.BVALID); end
      cyc = 0;
      while (bus.AWREADY !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL b2b_timeout2: second AWREADY still low after %0d cycles", cyc); end
      @(posedge clk); #1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      n_cmp++;
      if (bus.BVALID !== 1'b1) begin n_err++; $display("FAIL b2b_second_b: BVALID %b want 1", bus.BVALID); end
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
      sb.push_back(exp_t'{OKAY, 32'h06});
      do_read(5'h04, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL b2b_enable: got %h/%b want %h/%b", d, r, e.data, e.resp); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      int          cyc;
      @(posedge clk); #1;
      bus.ARADDR = 5'h04; bus.ARVALID = 1'b1;
      cyc = 0;
      while (bus.ARREADY !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 20) begin n_cmp++; n_err++; $display("FAIL rst_rd_timeout: ARREADY still low after %0d cycles", cyc); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_read: RVALID %b ARREADY %b want 0/0", bus.RVALID, bus.ARREADY);
      end
      bus.ARVALID = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.push_back(exp_t'{OKAY, 32'h0});
      do_read(5'h04, d, r);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data || r !== e.resp) begin n_err++; $display("FAIL rst_enable_cleared: got %h/%b want %h/%b", d, r, e.data, e.resp); end
   endtask

   initial begin
      bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
      test_reset();
      test_pulse();
      test_level();
      test_errors();
      test_strobe();
`ifdef SOC_IRQ_CTRL_EDGE_EN
      test_edge();
`endif
      test_back_to_back();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/soc_irq_ctrl.md
# soc_irq_ctrl

AXI-Lite interrupt controller that sits directly downstream of the SoC timer and other peripherals. It collects up to 32 interrupt request lines, starting with the timer's `irq` on `irq_src[0]`. It latches them into a pending register, masks them with a software enable register, and drives one aggregated interrupt line to the CPU. Software finds the highest-priority source through a claim register and acknowledges it through a write-1-to-clear register.

## Interface
- `ADDR_WIDTH`, 5: AXI-Lite byte address width (32-byte register window).
- `DATA_WIDTH`, 32: AXI-Lite data width. Only 32 is supported.
- `NUM_IRQ`, 8: number of interrupt sources. Legal range is 1..32.
- `ACLK`  in  1: the only clock.
- `ARESET`  in  1: synchronous, active-high reset.
- `AWADDR`  in  ADDR_WIDTH: write address.
- `AWVALID` in 1 / `AWREADY` out 1: write address handshake.
- `WDATA`  in  32: write data.
- `WSTRB`  in  4: write byte strobes.
- `WVALID` in 1 / `WREADY` out 1: write data handshake.
- `BRESP`  out  2: write response; `BVALID` out 1, `BREADY` in 1.
- `ARADDR`  in  ADDR_WIDTH: read address.
- `ARVALID` in 1 / `ARREADY` out 1: read address handshake.
- `RDATA`  out  32: read data; `RRESP` out 2; `RVALID` out 1; `RREADY` in 1.
- `irq_src`  in  NUM_IRQ: interrupt sources. They are synchronous to ACLK and active-high.
- `irq_out`  out  1: aggregated interrupt to the CPU. It is registered.

## Operation
Register map (byte offsets; bits at or above NUM_IRQ read as 0 and ignore writes):
- 0x00 RAW (RO): current `irq_src`.
- 0x04 ENABLE (RW): per-source enable. Reset value is 0.
- 0x08 PENDING (RO): latched requests.
- 0x0C CLEAR (WO): writing 1 to a bit clears that PENDING bit.
- 0x10 CLAIM (RO): bit31 is valid, meaning `|(PENDING & ENABLE)` is nonzero. Bits[4:0] hold the lowest set index of `PENDING & ENABLE`, or 0 if none. Reading CLAIM has no side effects.
- 0x14 EDGE_SEL (RW, present only with the configuration macro): 1 selects edge mode, 0 selects level mode. Reset value is 0.

Pending logic:
- Level mode: PENDING[i] is set on every edge where `irq_src[i]` is 1.
- Edge mode: PENDING[i] is set when `irq_src[i]` is 1 and `src_d[i]` is 0. `src_d` is the registered previous sample and resets to 0.
- Set and clear in the same cycle: set wins. A level source that is still high therefore re-pends immediately after a clear.
- Pending bits latch regardless of ENABLE. Enabling a source that is already pending raises `irq_out`.

Output:
- `irq_out` is registered as `|(PENDING & ENABLE)`.

AXI-Lite write:
- AWREADY and WREADY pulse high together for one cycle when AWVALID, WVALID and !BVALID are all true. AW and W are accepted only as a pair.
- Register update and BVALID both occur on the edge after acceptance.
- BVALID is held until BREADY. No new write is accepted while BVALID is high.
- BRESP is OKAY for ENABLE, CLEAR and EDGE_SEL.
- BRESP is SLVERR for RAW, PENDING, CLAIM, unmapped offsets, or an address with bits[1:0] nonzero. A SLVERR write leaves state unchanged.
- WSTRB masks byte lanes on every writable register, including CLEAR.

AXI-Lite read:
- ARREADY pulses for one cycle when ARVALID and !RVALID are both true.
- RDATA, RRESP and RVALID are registered on the following edge.
- RDATA is held stable until RREADY.
- RRESP is SLVERR with RDATA 0 for CLEAR, unmapped offsets or misaligned addresses.
- Reads and writes are independent and may complete in the same cycle.

## Timing
- Reset: the following are all 0 on the first edge with ARESET high.
  - Outputs: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA, irq_out.
  - State: ENABLE, PENDING, EDGE_SEL, src_d.
- An in-flight transaction is dropped by reset. The master must re-issue it.
- Source to pin: `irq_src[i]` rises before edge k, so PENDING[i] is 1 after edge k, and `irq_out` is 1 after edge k+1 if the source is enabled.
- CLEAR to pin: a write accepted at edge k updates PENDING at edge k+1. `irq_out` then drops at edge k+2 if nothing else is pending and enabled.
- Write latency: acceptance to BVALID is 1 cycle. Minimum back-to-back write rate is one write per 2 cycles.
- Read latency: ARREADY to RVALID is 1 cycle. The returned value is the register state at the acceptance edge.

## Configuration
- `SOC_IRQ_CTRL_EDGE_EN`:
  - Defined: the EDGE_SEL register and the `src_d` edge detector are built, giving per-source edge or level selection.
  - Undefined: all sources are level-sensitive. Offset 0x14 behaves as unmapped (SLVERR on read and write) and no `src_d` flops are inferred.

## Test plan
- Reset, then read all registers. Required: every readable register returns 0, RRESP is OKAY, and irq_out is 0.
- ENABLE=0x01, pulse irq_src[0] for 1 cycle, then read PENDING. Required: PENDING=0x01, irq_out=1 two cycles after the pulse, CLAIM=0x8000_0000. Then write CLEAR=0x01. Required: PENDING=0 and irq_out=0 at acceptance +2 cycles.
- irq_src=0x0C held high with ENABLE=0x08. Required: CLAIM=0x8000_0003. Then write CLEAR=0x0C while the sources are still high. Required: PENDING stays 0x0C because set wins.
- Write to 0x00, write with AWADDR=0x06, and read 0x0C. Required: SLVERR in all three cases and no state change.
- With the macro defined, write EDGE_SEL=0x02 and hold irq_src[1] high for 10 cycles. Required: the bit pends exactly once, and after a clear it remains 0 until the next rising edge.
- With BREADY held low for 5 cycles after a write: required BVALID is held and a second AW/W pair is not accepted until B completes. Assert ARESET mid-read: required RVALID=0 on the next edge.
